// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MEM_LAT = 1;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between the fetch and data ports.
// On a tie the port that did not win last time is chosen; the caller
// pins last_i to PORT_IF when it wants the data port to always win.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic  if_req_i,
    input  logic  d_req_i,
    input  port_e last_i,
    output port_e win_o
);

    // Pick the requester; a tie goes to the port opposite the last winner.
    always_comb begin
        win_o = PORT_D;
        if (if_req_i && d_req_i) begin
            if (last_i == PORT_D) begin
                win_o = PORT_IF;
            end else begin
                win_o = PORT_D;
            end
        end else if (if_req_i) begin
            win_o = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a fixed-latency memory.
// Build option: ARB_ROUND_ROBIN_EN -- alternate tie winners; when undefined
// the data port always wins a tie.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates and captures the winner
// ACCESS | memory enabled for MEM_LAT cycles from the captured request
// RESP   | returns the sampled read data to the winner next cycle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    port_e             pick;
    port_e             last_ptr;

`ifdef ARB_ROUND_ROBIN_EN
    port_e last_q, last_d;
    assign last_ptr = last_q;
`else
    assign last_ptr = PORT_IF;
`endif

    arb_pick u_arb_pick (
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .last_i   (last_ptr),
        .win_o    (pick)
    );

    // Next-state, capture and response logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    win_d   = pick;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = pick;
`endif
                    if (pick == PORT_D) begin
                        d_gnt_d = 1'b1;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        // Fetch is read-only: never carry a write into memory.
                        if_gnt_d = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (win_q == PORT_D) begin
                    d_valid_d = 1'b1;
                    d_rdata_d = rdata_q;
                end else begin
                    if_valid_d = 1'b1;
                    if_rdata_d = rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= PORT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= PORT_IF;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the address width to match the 8-bit PC.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, giving memory cycles per access; the legal range is 1..7.
REQ-004 The block SHALL have one clock, clk (input, 1), with all logic on its rising edge.
REQ-005 The block SHALL have reset (input, 1); reset is synchronous and active-high.
REQ-006 Fetch port: if_req in 1 (request), if_addr in ADDR_W (address), if_gnt out 1 (accepted), if_valid out 1 (data ready), if_rdata out DATA_W (data).
REQ-007 Data port: d_req in 1, d_we in 1 (write), d_addr in ADDR_W, d_wdata in DATA_W, d_gnt out 1, d_valid out 1, d_rdata out DATA_W.
REQ-008 Memory side: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W.
REQ-009 The block SHALL have busy (output, 1), high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, ACCESS and RESP, with a 2-bit encoding.
REQ-011 IDLE->ACCESS SHALL occur when any req is sampled high; otherwise the FSM stays in IDLE.
REQ-012 On the IDLE->ACCESS edge, the winner's gnt SHALL be a one-cycle registered pulse, and addr/we/wdata SHALL be captured into registers.
REQ-013 In ACCESS, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be driven from the captured registers; a 3-bit counter SHALL count MEM_LAT cycles.
REQ-014 ACCESS->RESP SHALL occur after exactly MEM_LAT cycles; mem_rdata SHALL be sampled on that edge.
REQ-015 In RESP, the winner's valid SHALL be a one-cycle pulse with rdata held until the next valid on that port; for writes, d_rdata SHALL be 0.
REQ-016 RESP->IDLE SHALL occur unconditionally; the minimum spacing between grants SHALL be MEM_LAT+2 cycles.
REQ-017 Latency SHALL be: req sampled in cycle N gives gnt in N+1 and valid in N+MEM_LAT+2.
REQ-018 A requester SHALL hold req until gnt; dropping req before gnt SHALL cancel the request with no side effect.
REQ-019 Dropping req after gnt SHALL NOT abort the transaction.
REQ-020 Requests arriving during ACCESS or RESP SHALL wait, and SHALL be arbitrated on the next IDLE cycle.
REQ-021 The fetch port SHALL be read-only; mem_we SHALL be 0 on every fetch access.
REQ-022 At most one gnt and at most one valid SHALL be high in any cycle.
REQ-023 When not in ACCESS, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-024 During reset, the state SHALL be IDLE and the counter 0.
REQ-025 During reset, every output SHALL be 0: gnt, valid, rdata, mem_*, busy.
REQ-026 The last-winner pointer SHALL reset to "fetch", so the data port wins the first tie.
REQ-027 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction: mem_en is 0 the next cycle and no valid pulse is emitted.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the port not granted last, and the pointer SHALL update on each grant.
REQ-029 With ARB_ROUND_ROBIN_EN undefined, the data port SHALL always win a tie, and the pointer logic SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, ACCESS=1, RESP=2), the port IDs (PORT_IF=0, PORT_D=1) and the default widths.
REQ-031 One sub-module, arb_pick, SHALL be a combinational winner selection taking the two reqs and the last-winner pointer.
REQ-032 The FSM, counter and capture registers SHALL stay in mem_arbiter.

Verification
REQ-033 Single fetch: MEM_LAT=1, if_req=1 at cycle 0 with if_addr=0x10 and mem returning 0xBEEF -> if_gnt at 1, mem_en in cycle 1 only, if_valid at 3 with if_rdata=0xBEEF.
REQ-034 Write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 for one cycle, then d_valid with d_rdata=0.
REQ-035 Tie with ARB_ROUND_ROBIN_EN: both reqs held for four transactions -> grant order D, IF, D, IF; without the macro -> D, D, D, D.
REQ-036 MEM_LAT=3 read -> mem_en high for 3 cycles, valid 5 cycles after the req cycle, and no second gnt before cycle 6.
REQ-037 Reset pulse in the second ACCESS cycle (MEM_LAT=3) -> mem_en=0 and busy=0 the next cycle, and no valid is ever seen.
REQ-038 if_req raised for one cycle during d's ACCESS then dropped -> no if_gnt, and memory is untouched by fetch.
